instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream stage of the 19-bit CPU core.
- Generates sequential instruction addresses and issues read requests to the separate instruction memory (Harvard organisation).
- Buffers returned 19-bit instruction words in a small prefetch FIFO and presents them to the core with a valid/ready handshake.
- Accepts redirects (JMP/BEQ/BNE/CALL/RET targets) from the core, flushing stale prefetches and discarding in-flight responses.

Parameters:
- ADDR_W, 19, instruction address width
- DATA_W, 19, instruction word width
- DEPTH, 4, prefetch FIFO entries (power of two, 2..16)
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  enables request issue; low = fetch stalls, FIFO contents retained
- imem_req  out  1  read request, one-cycle qualifier per accepted address
- imem_addr  out  ADDR_W  read address, valid with imem_req
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; responses in order, latency >= 1 cycle
- imem_rdata  in  DATA_W  read data
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  core consumes head
- instruction  out  DATA_W  FIFO head instruction word
- instr_pc  out  ADDR_W  address of head instruction
- redirect_valid  in  1  core requests fetch restart
- redirect_pc  in  ADDR_W  restart address
- busy  out  1  high when outstanding != 0 or FIFO non-empty

Behaviour:
- Reset (async, rst_n low):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state = RUN.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, busy=0.
  - Reset mid-transaction drops everything. Responses arriving after reset release are ignored while discard = 0 and outstanding = 0.
- Request issue:
  - imem_req = fetch_en & (state==RUN) & (fifo_count + outstanding < DEPTH) & ~redirect_valid.
  - A request holds imem_addr stable until imem_gnt.
  - On req&gnt: outstanding+1, fetch_pc+1.
  - fetch_pc wraps 2^ADDR_W-1 -> 0.
- Response:
  - In RUN, imem_rvalid pushes {fetch address, rdata} into the FIFO; outstanding-1.
  - The address is tracked by a separate resp_pc counter that increments per accepted response.
  - The credit rule guarantees the FIFO never overflows; a push when full is an assertion failure.
- Output:
  - instruction/instr_pc are registered FIFO head values, valid same cycle as instr_valid.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - When the FIFO is empty, a response arriving this cycle appears at the head the next cycle (minimum latency gnt -> instr_valid = memory latency + 1).
- Redirect (highest priority):
  - FIFO flushed that cycle; any pop that cycle is ignored.
  - discard = outstanding (excluding any response arriving that same cycle, which is itself dropped).
  - fetch_pc = resp_pc = redirect_pc.
  - state = FLUSH if discard != 0, else RUN.
  - No request is issued in the redirect cycle.
- FLUSH state:
  - No requests. Each imem_rvalid is dropped and decrements discard and outstanding.
  - discard reaching 0 -> RUN the next cycle.
  - A further redirect in FLUSH updates fetch_pc/resp_pc only; discard continues.
- fetch_en low: no new requests; outstanding responses still accepted; handshake to the core continues.
- busy is combinational from registered state.

Test Plan:
- Reset, fetch_en=1, memory latency 1 returning rdata = addr ^ 19'h55555, instr_ready=1 -> instr_pc 0,1,2,3… consecutive every cycle after initial latency 2; instruction(0) = 19'h55555.
- instr_ready=0 with DEPTH=4 -> exactly 4 grants, then imem_req stays 0; instr_valid held with instr_pc=0; release ready -> 4 pops in 4 cycles, then fetching resumes at address 4.
- Latency 3, two requests outstanding, redirect_pc=19'h00100 -> both stale responses dropped, next instr_pc=0x00100, no request issued until discard=0.
- redirect_valid coincident with instr_valid&instr_ready and imem_rvalid -> neither pop nor push recorded; FIFO empty next cycle; next delivered instr_pc = redirect_pc.
- Redirect to 19'h7FFFE -> delivered instr_pc sequence 0x7FFFE, 0x7FFFF, 0x00000.
- Assert rst_n low with 3 entries buffered and 1 outstanding -> instr_valid=0, busy=0 immediately; after release, the late response is ignored and the first instr_pc = RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential address generation, credit-limited
// requests to instruction memory, prefetch FIFO and redirect flushing.
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W   = 19,
    parameter int unsigned        DATA_W   = 19,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] resp_pc_q;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic              valid_q;
    entry_t            entries_q [DEPTH];
    entry_t            entries_d [DEPTH];

    logic              accept_rsp_c;
    logic              gnt_c;
    logic              push_c;
    logic              pop_c;
    logic              credit_ok_c;
    logic [CNT_W-1:0]  wr_idx_c;

    // Handshake qualifiers; responses are only meaningful while something is outstanding
    always_comb begin
        accept_rsp_c = imem_rvalid && (outstanding_q != '0);
        gnt_c        = imem_req && imem_gnt;
        push_c       = (state_q == ST_RUN) && !redirect_valid && accept_rsp_c;
        pop_c        = valid_q && instr_ready && !redirect_valid;
        credit_ok_c  = (SUM_W'(fifo_count_q) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);
        wr_idx_c     = fifo_count_q - CNT_W'(pop_c);
    end

    // Outstanding and discard bookkeeping
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(gnt_c) - CNT_W'(accept_rsp_c);
        discard_d     = '0;
        if (state_q == ST_FLUSH) begin
            discard_d = discard_q - CNT_W'(accept_rsp_c);
        end else if (redirect_valid) begin
            discard_d = outstanding_q - CNT_W'(accept_rsp_c);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush until every stale response has been dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid && (discard_d != '0)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (discard_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Request issue: credit-limited so the FIFO can absorb every response
    always_comb begin
        imem_req = 1'b0;
        if (rst_n && fetch_en && (state_q == ST_RUN) && credit_ok_c && !redirect_valid) begin
            imem_req = 1'b1;
        end
    end

    // Shift-register FIFO next value: head always sits in entry 0
    always_comb begin
        fifo_count_d = fifo_count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        if (redirect_valid) begin
            fifo_count_d = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (pop_c) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                entries_d[i] = entries_q[IDX_W'(i + 1)];
            end
        end
        if (push_c) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx_c) begin
                    entries_d[i] = '{pc: resp_pc_q, data: imem_rdata};
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_count_q  <= '0;
            valid_q       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fifo_count_q  <= fifo_count_d;
            valid_q       <= (fifo_count_d != '0);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc;
                resp_pc_q  <= redirect_pc;
            end else begin
                if (gnt_c) begin
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
                end
                if (push_c) begin
                    resp_pc_q <= resp_pc_q + ADDR_W'(1);
                end
            end
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = valid_q;
    assign instruction = entries_q[0].data;
    assign instr_pc    = entries_q[0].pc;
    assign busy        = (outstanding_q != '0) || (fifo_count_q != '0);

    // The credit rule must make a push into a full FIFO impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_c && !pop_c && (fifo_count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        imem_req;
    logic [18:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [18:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [18:0] instruction;
    logic [18:0] instr_pc;
    logic        redirect_valid;
    logic [18:0] redirect_pc;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int unsigned lat = 1;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [18:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t pq[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    // Memory model: keeps its queue across DUT reset so late responses still arrive
    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            pq.push_back('{addr: imem_addr, due: cyc + lat});
        end
        if (pq.size() != 0 && pq[0].due <= cyc + 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= pq[0].addr ^ 19'h55555;
            void'(pq.pop_front());
        end else begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end
        cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_instr(input string tag, input logic [18:0] pc, input logic [18:0] ins);
        int n;
        n = 0;
        while (!instr_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(instr_valid), 32'(1));
        chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
        chk({tag, "_ins"}, 32'(instruction), 32'(ins));
        tick();
    endtask

    task automatic do_reset();
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b1;
        lat            = 1;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b1;
        tick();
        tick();

        // Reset values
        chk("rst_req", 32'(imem_req), 32'(0));
        chk("rst_addr", 32'(imem_addr), 32'(0));
        chk("rst_valid", 32'(instr_valid), 32'(0));
        chk("rst_instr", 32'(instruction), 32'(0));
        chk("rst_pc", 32'(instr_pc), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        tick();

        // Streaming at latency 1, with an initial grant stall holding the address
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        imem_gnt    = 1'b0;
        #1;
        chk("stall_req", 32'(imem_req), 32'(1));
        chk("stall_addr0", 32'(imem_addr), 32'(0));
        tick();
        chk("stall_addr1", 32'(imem_addr), 32'(0));
        chk("stall_valid", 32'(instr_valid), 32'(0));
        imem_gnt = 1'b1;
        tick();
        chk("t1_c1_valid", 32'(instr_valid), 32'(0));
        chk("t1_c1_addr", 32'(imem_addr), 32'(1));
        tick();
        chk("t1_c2_valid", 32'(instr_valid), 32'(1));
        chk("t1_c2_pc", 32'(instr_pc), 32'(0));
        chk("t1_c2_ins", 32'(instruction), 32'h55555);
        chk("t1_c2_busy", 32'(busy), 32'(1));
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t1_seq_valid", 32'(instr_valid), 32'(1));
            chk("t1_seq_pc", 32'(instr_pc), 32'(k));
            chk("t1_seq_ins", 32'(instruction), 32'(k) ^ 32'h55555);
        end

        // Back-pressure: FIFO fills with exactly DEPTH grants
        do_reset();
        begin
            int grants;
            grants   = 0;
            fetch_en = 1'b1;
            #1;
            for (int k = 0; k < 10; k++) begin
                if (imem_req && imem_gnt) grants++;
                tick();
            end
            chk("bp_grants", 32'(grants), 32'(4));
        end
        chk("bp_req", 32'(imem_req), 32'(0));
        chk("bp_valid", 32'(instr_valid), 32'(1));
        chk("bp_pc", 32'(instr_pc), 32'(0));
        instr_ready = 1'b1;
        #1;
        chk("bp_pop0", 32'(instr_pc), 32'(0));
        tick();
        chk("bp_pop1", 32'(instr_pc), 32'(1));
        chk("bp_resume_req", 32'(imem_req), 32'(1));
        chk("bp_resume_addr", 32'(imem_addr), 32'(4));
        tick();
        chk("bp_pop2", 32'(instr_pc), 32'(2));
        tick();
        chk("bp_pop3", 32'(instr_pc), 32'(3));
        tick();
        chk("bp_next4", 32'(instr_pc), 32'(4));
        chk("bp_next4_ins", 32'(instruction), 32'h55551);

        // Redirect with two responses in flight at latency 3
        do_reset();
        lat         = 3;
        instr_ready = 1'b1;
        fetch_en    = 1'b1;
        #1;
        chk("rd_c0_addr", 32'(imem_addr), 32'(0));
        tick();
        chk("rd_c1_addr", 32'(imem_addr), 32'(1));
        tick();
        fetch_en       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 19'h00100;
        #1;
        chk("rd_redir_req", 32'(imem_req), 32'(0));
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        #1;
        chk("rd_flush_req0", 32'(imem_req), 32'(0));
        chk("rd_flush_addr", 32'(imem_addr), 32'h00100);
        chk("rd_flush_busy", 32'(busy), 32'(1));
        tick();
        chk("rd_flush_req1", 32'(imem_req), 32'(0));
        chk("rd_flush_valid", 32'(instr_valid), 32'(0));
        tick();
        chk("rd_run_req", 32'(imem_req), 32'(1));
        chk("rd_run_addr", 32'(imem_addr), 32'h00100);
        expect_instr("rd_first", 19'h00100, 19'h55455);
        expect_instr("rd_second", 19'h00101, 19'h55454);

        // Redirect coincident with pop and an arriving response
        do_reset();
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("co_pre_valid", 32'(instr_valid), 32'(1));
        chk("co_pre_pc", 32'(instr_pc), 32'(1));
        redirect_valid = 1'b1;
        redirect_pc    = 19'h02000;
        #1;
        chk("co_req", 32'(imem_req), 32'(0));
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("co_empty", 32'(instr_valid), 32'(0));
        chk("co_busy", 32'(busy), 32'(0));
        chk("co_req_after", 32'(imem_req), 32'(1));
        chk("co_addr_after", 32'(imem_addr), 32'h02000);
        expect_instr("co_first", 19'h02000, 19'h57555);
        expect_instr("co_second", 19'h02001, 19'h57554);

        // Address wrap after redirect near the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 19'h7FFFE;
        tick();
        redirect_valid = 1'b0;
        expect_instr("wr_a", 19'h7FFFE, 19'h2AAAB);
        expect_instr("wr_b", 19'h7FFFF, 19'h2AAAA);
        expect_instr("wr_c", 19'h00000, 19'h55555);

        // Reset with three entries buffered and one response still in flight
        do_reset();
        fetch_en = 1'b1;
        tick();
        tick();
        tick();
        lat = 6;
        tick();
        chk("mr_valid", 32'(instr_valid), 32'(1));
        chk("mr_busy", 32'(busy), 32'(1));
        chk("mr_req", 32'(imem_req), 32'(0));
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        #1;
        chk("mr_rst_valid", 32'(instr_valid), 32'(0));
        chk("mr_rst_busy", 32'(busy), 32'(0));
        chk("mr_rst_pc", 32'(instr_pc), 32'(0));
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("mr_late_valid", 32'(instr_valid), 32'(0));
        chk("mr_late_busy", 32'(busy), 32'(0));
        lat         = 1;
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        expect_instr("mr_first", 19'h00000, 19'h55555);
        expect_instr("mr_second", 19'h00001, 19'h55554);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
